// File: rtl/pipe_adder_pkg.sv
// +--------------------------------------------------------------------------+
// | pipe_adder_pkg : shared mode encoding for the pipelined adder/subtractor |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package pipe_adder_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

endpackage : pipe_adder_pkg

`default_nettype wire

// File: rtl/pipe_adder_if.sv
// +--------------------------------------------------------------------------+
// | pipe_adder_if : operand/result handshake bundle of pipe_adder            |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pipe_adder_if #(
   parameter int DATA_WIDTH = 8
) ();
   import pipe_adder_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   mode_e                 mode;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] result;
   logic                  carry_out;
   logic                  overflow;

   modport master (
      output in_valid, mode, a, b, out_ready,
      input  in_ready, out_valid, result, carry_out, overflow
   );

   modport slave (
      input  in_valid, mode, a, b, out_ready,
      output in_ready, out_valid, result, carry_out, overflow
   );

endinterface : pipe_adder_if

`default_nettype wire

// File: rtl/pipe_adder_stage.sv
// +--------------------------------------------------------------------------+
// | pipe_adder_stage : one SEG-bit carry segment plus its pipeline register  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_adder_stage #(
   parameter int DATA_WIDTH = 8,
   parameter int SEG        = 4,
   parameter int IDX        = 0
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  up_valid,
   output logic                       up_ready,
   input  wire logic [DATA_WIDTH-1:0] up_a,
   input  wire logic [DATA_WIDTH-1:0] up_b,
   input  wire logic [DATA_WIDTH-1:0] up_sum,
   input  wire logic                  up_carry,
   output logic                       down_valid,
   input  wire logic                  down_ready,
   output logic [DATA_WIDTH-1:0]      down_a,
   output logic [DATA_WIDTH-1:0]      down_b,
   output logic [DATA_WIDTH-1:0]      down_sum,
   output logic                       down_carry
);

   localparam int LSB = IDX * SEG;

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [DATA_WIDTH-1:0] sum_q, sum_d;
   logic                  carry_q, carry_d;
   logic [SEG:0]          seg_sum;

   always_comb begin
      up_ready = !valid_q || down_ready;
      seg_sum  = {1'b0, up_a[LSB +: SEG]} + {1'b0, up_b[LSB +: SEG]}
               + {{SEG{1'b0}}, up_carry};
      valid_d  = valid_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      // Operands travel whole so the last stage can recover the MSB carry-in.
      if (up_ready) begin
         valid_d              = up_valid;
         a_d                  = up_a;
         b_d                  = up_b;
         sum_d                = up_sum;
         sum_d[LSB +: SEG]    = seg_sum[SEG-1:0];
         carry_d              = seg_sum[SEG];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
   end

   assign down_valid = valid_q;
   assign down_a     = a_q;
   assign down_b     = b_q;
   assign down_sum   = sum_q;
   assign down_carry = carry_q;

endmodule : pipe_adder_stage

`default_nettype wire

// File: rtl/pipe_adder.sv
// +--------------------------------------------------------------------------+
// | pipe_adder : STAGES-deep segmented adder/subtractor with valid/ready     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STAGES     = 2
) (
   input  wire logic   clk,
   input  wire logic   rst_n,
   pipe_adder_if.slave bus
);

   localparam int SEG = DATA_WIDTH / STAGES;

   if (DATA_WIDTH < 2 || STAGES < 1 || (DATA_WIDTH % STAGES) != 0) begin : g_bad_params
      $error("pipe_adder: DATA_WIDTH must be >= 2 and divisible by STAGES >= 1");
   end

   logic                  s_valid [STAGES+1];
   logic                  s_ready [STAGES+1];
   logic [DATA_WIDTH-1:0] s_a     [STAGES+1];
   logic [DATA_WIDTH-1:0] s_b     [STAGES+1];
   logic [DATA_WIDTH-1:0] s_sum   [STAGES+1];
   logic                  s_carry [STAGES+1];
   logic                  sub_op;
   logic                  msb_carry_in;
   logic                  unused_low_bits;

   // Subtraction is a + ~b + 1: invert b and seed the chain with carry 1.
   assign sub_op           = (bus.mode == MODE_SUB);
   assign s_valid[0]       = bus.in_valid;
   assign s_a[0]           = bus.a;
   assign s_b[0]           = sub_op ? ~bus.b : bus.b;
   assign s_sum[0]         = '0;
   assign s_carry[0]       = sub_op;
   assign s_ready[STAGES]  = bus.out_ready;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      pipe_adder_stage #(
         .DATA_WIDTH (DATA_WIDTH),
         .SEG        (SEG),
         .IDX        (k)
      ) u_stage (
         .clk        (clk),
         .rst_n      (rst_n),
         .up_valid   (s_valid[k]),
         .up_ready   (s_ready[k]),
         .up_a       (s_a[k]),
         .up_b       (s_b[k]),
         .up_sum     (s_sum[k]),
         .up_carry   (s_carry[k]),
         .down_valid (s_valid[k+1]),
         .down_ready (s_ready[k+1]),
         .down_a     (s_a[k+1]),
         .down_b     (s_b[k+1]),
         .down_sum   (s_sum[k+1]),
         .down_carry (s_carry[k+1])
      );
   end

   assign msb_carry_in    = s_a[STAGES][DATA_WIDTH-1] ^ s_b[STAGES][DATA_WIDTH-1]
                          ^ s_sum[STAGES][DATA_WIDTH-1];
   assign unused_low_bits = ^{s_a[STAGES][DATA_WIDTH-2:0], s_b[STAGES][DATA_WIDTH-2:0]};

   assign bus.in_ready  = rst_n & s_ready[0];
   assign bus.out_valid = s_valid[STAGES];
   assign bus.result    = s_valid[STAGES] ? s_sum[STAGES] : '0;
   assign bus.carry_out = s_valid[STAGES] & s_carry[STAGES];
   assign bus.overflow  = s_valid[STAGES] & (msb_carry_in ^ s_carry[STAGES]);

`ifdef FORMAL
   logic [DATA_WIDTH:0] ref_q [STAGES];

   always_ff @(posedge clk) begin
      if (s_ready[0]) begin
         ref_q[0] <= sub_op ? ({1'b0, bus.a} + {1'b0, ~bus.b} + 1'b1)
                            : ({1'b0, bus.a} + {1'b0, bus.b});
      end
      for (int k = 1; k < STAGES; k++) begin
         if (s_ready[k]) ref_q[k] <= ref_q[k-1];
      end
   end

   a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
      bus.out_valid && !bus.out_ready |=>
         $stable(bus.result) && $stable(bus.carry_out) && $stable(bus.overflow));

   a_result_ref: assert property (@(posedge clk) disable iff (!rst_n)
      bus.out_valid |-> {bus.carry_out, bus.result} == ref_q[STAGES-1]);
`endif

endmodule : pipe_adder

`default_nettype wire

// File: tb/tb_pipe_adder.sv
// +--------------------------------------------------------------------------+
// | tb_pipe_adder : directed and randomised checks of pipe_adder (8-bit, 2)  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_adder;
   import pipe_adder_pkg::*;

   localparam int NV = 10;
   localparam int NRAND = 10000;
   localparam logic       VM [NV] = '{0, 0, 0, 1, 1, 0, 1, 1, 0, 1};
   localparam logic [7:0] VA [NV] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h80, 8'h00, 8'h7F, 8'h08, 8'h10};
   localparam logic [7:0] VB [NV] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01, 8'h80, 8'h00, 8'hFF, 8'h08, 8'h01};
   localparam logic [7:0] VR [NV] = '{8'h10, 8'h00, 8'h80, 8'hFE, 8'h7F, 8'h00, 8'h00, 8'h80, 8'h10, 8'h0F};
   localparam logic       VC [NV] = '{0, 1, 0, 0, 1, 1, 1, 0, 0, 1};
   localparam logic       VO [NV] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0};

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   pipe_adder_if #(.DATA_WIDTH(8)) bus ();

   pipe_adder #(.DATA_WIDTH(8), .STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference packed as {overflow, carry_out, result}
   function automatic logic [9:0] model(input logic m, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      logic       o;
      if (m) begin
         s = {1'b0, a} + {1'b0, ~b} + 9'd1;
         o = (a[7] != b[7]) && (s[7] != a[7]);
      end else begin
         s = {1'b0, a} + {1'b0, b};
         o = (a[7] == b[7]) && (s[7] != a[7]);
      end
      return {o, s[8], s[7:0]};
   endfunction

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.mode      = MODE_ADD;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
      end
      n_checks++;
      if ({bus.out_valid, bus.overflow, bus.carry_out, bus.result} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b o=%b c=%b r=%h want all 0",
                  bus.out_valid, bus.overflow, bus.carry_out, bus.result);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_arith();
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            if ({bus.out_valid, bus.overflow, bus.carry_out, bus.result} !== 11'd0) begin
               n_fail++;
               $display("FAIL idle_zero[%0d]: got v=%b o=%b c=%b r=%h want all 0",
                        i, bus.out_valid, bus.overflow, bus.carry_out, bus.result);
            end
         end
         bus.in_valid = 1'b1;
         bus.mode     = mode_e'(VM[i]);
         bus.a        = VA[i];
         bus.b        = VB[i];
         #1;
         n_checks++;
         if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL arith_in_ready[%0d]: got %b want 1", i, bus.in_ready);
         end
         @(negedge clk);
         bus.in_valid = 1'b0;
         n_checks++;
         if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL arith_early[%0d]: out_valid got %b want 0", i, bus.out_valid);
         end
         @(negedge clk);
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.result !== VR[i] ||
             bus.carry_out !== VC[i] || bus.overflow !== VO[i]) begin
            n_fail++;
            $display("FAIL arith[%0d]: got v=%b r=%h c=%b o=%b want v=1 r=%h c=%b o=%b",
                     i, bus.out_valid, bus.result, bus.carry_out, bus.overflow, VR[i], VC[i], VO[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] ta [6];
      logic [7:0] tb [6];
      logic       tm [6];
      logic [9:0] exp;
      for (int i = 0; i < 6; i++) begin
         ta[i] = 8'(i * 8'h23 + 8'h05);
         tb[i] = 8'(8'hF0 - i * 8'h11);
         tm[i] = i[0];
      end
      bus.out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_checks++;
         if (c >= 2 && c < 8) begin
            exp = model(tm[c-2], ta[c-2], tb[c-2]);
            if (bus.out_valid !== 1'b1 || {bus.overflow, bus.carry_out, bus.result} !== exp) begin
               n_fail++;
               $display("FAIL b2b_out[%0d]: got v=%b o=%b c=%b r=%h want v=1 o=%b c=%b r=%h",
                        c - 2, bus.out_valid, bus.overflow, bus.carry_out, bus.result,
                        exp[9], exp[8], exp[7:0]);
            end
         end else if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_bubble[%0d]: out_valid got %b want 0", c, bus.out_valid);
         end
         if (c < 6) begin
            bus.in_valid = 1'b1;
            bus.mode     = mode_e'(tm[c]);
            bus.a        = ta[c];
            bus.b        = tb[c];
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
               n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, bus.in_ready);
            end
         end else begin
            bus.in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_stall();
      logic [7:0] got [8];
      logic [7:0] want [3];
      int         n_got = 0;
      logic       acc;
      want = '{8'h03, 8'h30, 8'h77};
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.mode      = MODE_ADD;
      bus.a = 8'h01; bus.b = 8'h02;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL stall_first_ready: got %b want 1", bus.in_ready);
      end
      @(negedge clk);
      bus.a = 8'h10; bus.b = 8'h20;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL stall_second_ready: got %b want 1", bus.in_ready);
      end
      @(negedge clk);
      bus.a = 8'h33; bus.b = 8'h44;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== 8'h03) begin
         n_fail++;
         $display("FAIL stall_full: got in_ready=%b v=%b r=%h want in_ready=0 v=1 r=03",
                  bus.in_ready, bus.out_valid, bus.result);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== 8'h03 ||
          bus.carry_out !== 1'b0 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_hold: got in_ready=%b v=%b r=%h c=%b o=%b want 0 1 03 0 0",
                  bus.in_ready, bus.out_valid, bus.result, bus.carry_out, bus.overflow);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (bus.out_valid === 1'b1) begin
            got[n_got] = bus.result;
            n_got++;
         end
         acc = bus.in_valid && bus.in_ready;
         @(negedge clk);
         if (acc) bus.in_valid = 1'b0;
      end
      n_checks++;
      if (n_got != 3 || got[0] !== want[0] || got[1] !== want[1] || got[2] !== want[2]) begin
         n_fail++;
         $display("FAIL stall_drain: got %0d beats (%h %h %h) want 3 beats (03 30 77)",
                  n_got, got[0], got[1], got[2]);
      end
      n_checks++;
      if (bus.in_valid !== 1'b0) begin
         n_fail++; $display("FAIL stall_third_accept: in_valid still %b want 0", bus.in_valid);
      end
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.mode      = MODE_ADD;
      bus.a = 8'h11; bus.b = 8'h22;
      @(negedge clk);
      bus.a = 8'h44; bus.b = 8'h55;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_full: got v=%b in_ready=%b want 1 0", bus.out_valid, bus.in_ready);
      end
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.result !== 8'h00 || bus.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_flush: got v=%b r=%h in_ready=%b want 0 00 0",
                  bus.out_valid, bus.result, bus.in_ready);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL midrst_release: in_ready got %b want 1", bus.in_ready);
      end
      bus.out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         #1;
         if (bus.out_valid === 1'b1) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++; $display("FAIL midrst_stale: got %0d stale beats want 0", seen);
      end
      bus.in_valid = 1'b1;
      bus.mode     = MODE_SUB;
      bus.a = 8'h22; bus.b = 8'h11;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 8'h11 ||
          bus.carry_out !== 1'b1 || bus.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_after: got v=%b r=%h c=%b o=%b want 1 11 1 0",
                  bus.out_valid, bus.result, bus.carry_out, bus.overflow);
      end
   endtask

   task automatic test_random();
      logic [9:0] q [$];
      logic [9:0] exp;
      logic [9:0] hold_val = '0;
      logic       hold_v   = 1'b0;
      logic       in_fire  = 1'b0;
      int         sent     = 0;
      int         recv     = 0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int cyc = 0; cyc < 60000 && (sent < NRAND || recv < sent); cyc++) begin
         @(negedge clk);
         if (hold_v) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || {bus.overflow, bus.carry_out, bus.result} !== hold_val) begin
               n_fail++;
               $display("FAIL rand_hold@%0d: got v=%b {o,c,r}=%h want v=1 %h",
                        cyc, bus.out_valid, {bus.overflow, bus.carry_out, bus.result}, hold_val);
            end
         end
         if (!bus.in_valid || in_fire) begin
            if (sent < NRAND && $urandom_range(3) != 0) begin
               bus.in_valid = 1'b1;
               bus.mode     = mode_e'($urandom_range(1));
               bus.a        = 8'($urandom);
               bus.b        = 8'($urandom);
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         bus.out_ready = ($urandom_range(3) != 0);
         #1;
         in_fire = bus.in_valid && bus.in_ready;
         if (in_fire) begin
            q.push_back(model(bus.mode == MODE_SUB, bus.a, bus.b));
            sent++;
         end
         if (bus.out_valid !== 1'b1 && {bus.overflow, bus.carry_out, bus.result} !== 10'd0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rand_idle_zero@%0d: got {o,c,r}=%h want 000", cyc,
                     {bus.overflow, bus.carry_out, bus.result});
         end
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            n_checks++;
            recv++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_extra@%0d: got {o,c,r}=%h want no beat", cyc,
                        {bus.overflow, bus.carry_out, bus.result});
            end else begin
               exp = q.pop_front();
               if ({bus.overflow, bus.carry_out, bus.result} !== exp) begin
                  n_fail++;
                  $display("FAIL rand_beat[%0d]: got {o,c,r}=%h want %h", recv - 1,
                           {bus.overflow, bus.carry_out, bus.result}, exp);
               end
            end
         end
         hold_v   = bus.out_valid && !bus.out_ready;
         hold_val = {bus.overflow, bus.carry_out, bus.result};
      end
      n_checks++;
      if (sent != NRAND || recv != sent || q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_complete: got sent=%0d recv=%0d pending=%0d want %0d %0d 0",
                  sent, recv, q.size(), NRAND, NRAND);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_arith();
      test_back_to_back();
      test_stall();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pipe_adder

`default_nettype wire

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 2, pipeline depth and number of carry-chain segments; SHALL be >= 1 and divide DATA_WIDTH exactly (elaboration error otherwise).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 mode  input  1  0 = add, 1 = subtract (a - b); sampled with operands.
REQ-008 a  input  DATA_WIDTH  first operand.
REQ-009 b  input  DATA_WIDTH  second operand.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  DATA_WIDTH  sum/difference modulo 2^DATA_WIDTH.
REQ-013 carry_out  output  1  unsigned carry (add) / not-borrow (sub).
REQ-014 overflow  output  1  two's-complement signed overflow.

Function
REQ-015 Handshake: input beat SHALL transfer when in_valid && in_ready; output beat SHALL transfer when out_valid && out_ready.
REQ-016 Subtract SHALL be computed as a + ~b + 1: b inverted and carry-in 1 to segment 0.
REQ-017 Operands SHALL be split into STAGES segments of SEG = DATA_WIDTH/STAGES bits; stage k SHALL add segment k using the carry registered by stage k-1; unprocessed upper segments and already-computed lower result bits SHALL travel through pipeline registers alongside.
REQ-018 Each stage SHALL hold one valid bit; stage k SHALL advance when it is empty or stage k+1 advances (last stage: out_ready); a stage SHALL NOT advance while its downstream stage is full and holding.
REQ-019 in_ready SHALL equal "stage 0 can advance", a combinational function of the valid bits and out_ready only, never of in_valid.
REQ-020 Unstalled latency SHALL be exactly STAGES cycles from input transfer to out_valid asserted; throughput one beat per cycle.
REQ-021 Results SHALL leave in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-022 While out_valid && !out_ready, result, carry_out and overflow SHALL hold stable.
REQ-023 carry_out SHALL be the carry from the MSB of the full-width operation; overflow SHALL be carry into MSB XOR carry out of MSB.
REQ-024 Simultaneous input and output transfer on a full pipeline SHALL be sustained with no bubble.
REQ-025 result, carry_out, overflow SHALL be 0 whenever out_valid is 0.

Reset
REQ-026 With rst_n low at a rising edge, all stage valid bits SHALL clear, and result, carry_out, overflow SHALL be 0 from the next cycle.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight beats; none SHALL appear after reset deasserts.
REQ-028 in_ready SHALL be 0 while rst_n is low and SHALL be 1 in the first cycle after release.

Structure
REQ-029 Shared package pipe_adder_pkg SHALL hold the mode encoding (MODE_ADD = 0, MODE_SUB = 1) as a typedef'd enum.
REQ-030 One sub-module pipe_adder_stage (SEG-bit segment adder with carry in/out, valid bit and hold logic) SHALL be instantiated STAGES times via generate.
REQ-031 Formal properties (under FORMAL): output stability under stall; result equal to reference a op b computed at acceptance.

Verification (DATA_WIDTH=8, STAGES=2)
REQ-032 add a=0x0F b=0x01, out_ready=1 -> 2 cycles later result=0x10, carry_out=0, overflow=0.
REQ-033 add a=0xFF b=0x01 -> result=0x00, carry_out=1, overflow=0; add a=0x7F b=0x01 -> result=0x80, carry_out=0, overflow=1.
REQ-034 sub a=0x05 b=0x07 -> result=0xFE, carry_out=0, overflow=0; sub a=0x80 b=0x01 -> result=0x7F, carry_out=1, overflow=1.
REQ-035 out_ready=0, offer 3 beats back-to-back -> 2 accepted, in_ready=0 on the third; raise out_ready -> all 3 results in order, no duplicates.
REQ-036 Random 10k beats with random in_valid/out_ready -> every result matches scoreboard, order preserved.
REQ-037 rst_n low for 1 cycle with both stages full -> out_valid=0 next cycle, in_ready=1 after release, no stale result emitted.
